// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding and byte width.
package instr_loader_pkg;

    localparam int BYTE_WID = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ASSEMBLE = 3'd1,
        S_WRITE    = 3'd2,
        S_CHECK    = 3'd3,
        S_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and cache-write output of the instruction loader.
// Byte handshake: a byte transfers on a rising edge where byte_valid_i and byte_ready_o are both 1.
interface instruction_loader_if #(
    parameter int addr_wid  = 64,
    parameter int instr_wid = 32
);
    import instr_loader_pkg::*;

    logic                 byte_valid_i;
    logic [BYTE_WID-1:0]  byte_i;
    logic                 byte_ready_o;
    logic                 wr_instr_en_o;
    logic [instr_wid-1:0] wr_instr_o;
    logic [addr_wid-1:0]  wr_addr_o;

    modport master (
        output byte_valid_i, byte_i,
        input  byte_ready_o, wr_instr_en_o, wr_instr_o, wr_addr_o
    );

    modport slave (
        input  byte_valid_i, byte_i,
        output byte_ready_o, wr_instr_en_o, wr_instr_o, wr_addr_o
    );

endinterface

// File: rtl/instruction_loader_byte_packer.sv
// byte_packer: little-endian byte-to-word assembly with byte count and word-complete flag.
module byte_packer
    import instr_loader_pkg::*;
#(
    parameter int instr_wid = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 byte_en_i,
    input  logic [BYTE_WID-1:0]  byte_i,
    output logic [instr_wid-1:0] word_o,
    output logic                 word_complete_o
);

    localparam int bytes_per_word = instr_wid >> 3;
    localparam int cnt_wid        = (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;

    logic [cnt_wid-1:0]   cnt_q, cnt_d;
    logic [instr_wid-1:0] word_q, word_d;

    assign word_complete_o = byte_en_i && (cnt_q == cnt_wid'(bytes_per_word - 1));

    // Shifting in from the top leaves the first byte in [7:0] after a full word.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_en_i) begin
            word_d = {byte_i, word_q[instr_wid-1:BYTE_WID]};
            cnt_d  = word_complete_o ? '0 : cnt_q + cnt_wid'(1);
        end
    end

    // word_o already includes a byte accepted this cycle.
    assign word_o = word_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: assembles a byte stream into words and writes them to an instruction cache.
// Optional trailing-checksum word enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instruction_loader
    import instr_loader_pkg::*;
#(
    parameter int addr_wid       = 64,
    parameter int instr_wid      = 32,
    parameter int length         = 100,
    parameter int bytes_per_word = instr_wid >> 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [15:0]          num_words_i,
    instruction_loader_if.slave  bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output state_e               state_o
);

    state_e               state_q, state_d;
    logic [addr_wid-1:0]  addr_q, addr_d;
    logic [15:0]          words_q, words_d;
    logic [15:0]          target_q, target_d;
    logic [instr_wid-1:0] wr_instr_q, wr_instr_d;
    logic [addr_wid-1:0]  wr_addr_q, wr_addr_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [instr_wid-1:0] xor_q, xor_d;
    logic                 err_q, err_d;
`endif

    logic                 accept;
    logic                 packer_clear;
    logic [instr_wid-1:0] packed_word;
    logic                 word_complete;
    logic [15:0]          clamped;

    assign clamped = (num_words_i > 16'(length)) ? 16'(length) : num_words_i;
    assign accept  = bus.byte_valid_i && bus.byte_ready_o;

    byte_packer #(.instr_wid(instr_wid)) u_packer (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (packer_clear),
        .byte_en_i       (accept),
        .byte_i          (bus.byte_i),
        .word_o          (packed_word),
        .word_complete_o (word_complete)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_d      = words_q;
        target_d     = target_q;
        wr_instr_d   = wr_instr_q;
        wr_addr_d    = wr_addr_q;
        packer_clear = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        xor_d        = xor_q;
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    target_d     = clamped;
                    addr_d       = '0;
                    words_d      = '0;
                    packer_clear = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    xor_d        = '0;
                    err_d        = 1'b0;
`endif
                    state_d      = (clamped == 16'd0) ? S_DONE : S_ASSEMBLE;
                end
            end
            S_ASSEMBLE: begin
                if (word_complete) state_d = S_WRITE;
            end
            S_WRITE: begin
                addr_d     = addr_q + addr_wid'(bytes_per_word);
                words_d    = words_q + 16'd1;
                wr_instr_d = packed_word;
                wr_addr_d  = addr_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
                xor_d      = xor_q ^ packed_word;
                state_d    = (words_q + 16'd1 == target_q) ? S_CHECK : S_ASSEMBLE;
`else
                state_d    = (words_q + 16'd1 == target_q) ? S_DONE : S_ASSEMBLE;
`endif
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (word_complete) begin
                    err_d   = (packed_word != xor_q);
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            words_q    <= '0;
            target_q   <= '0;
            wr_instr_q <= '0;
            wr_addr_q  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            target_q   <= target_d;
            wr_instr_q <= wr_instr_d;
            wr_addr_q  <= wr_addr_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
            err_q      <= err_d;
`endif
        end
    end

    // Write bus shows the live word during WRITE and holds the last written values otherwise.
    assign bus.byte_ready_o  = (state_q == S_ASSEMBLE) || (state_q == S_CHECK);
    assign bus.wr_instr_en_o = (state_q == S_WRITE);
    assign bus.wr_instr_o    = (state_q == S_WRITE) ? packed_word : wr_instr_q;
    assign bus.wr_addr_o     = (state_q == S_WRITE) ? addr_q : wr_addr_q;

    assign busy_o  = (state_q == S_ASSEMBLE) || (state_q == S_WRITE) || (state_q == S_CHECK);
    assign done_o  = (state_q == S_DONE);
    assign state_o = state_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader (default build; checksum paths under INSTR_LOADER_CHECKSUM_EN).
module tb_instruction_loader;
    import instr_loader_pkg::*;

    localparam int W = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_words = '0;
    logic        busy, done, err;
    state_e      state;

    int num_checks  = 0;
    int num_fail    = 0;
    int write_count = 0;

    logic [W-1:0] exp_instr_q[$];
    logic [W-1:0] exp_addr_q[$];

    instruction_loader_if #(.addr_wid(64), .instr_wid(32)) bus ();

    instruction_loader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .num_words_i (num_words),
        .bus         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .state_o     (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the head of the expected queues.
    always @(negedge clk) begin
        if (bus.wr_instr_en_o) begin
            write_count++;
            if (exp_instr_q.size() == 0) begin
                check("spurious_wr", {63'd0, bus.wr_instr_en_o}, 64'd0);
            end else begin
                check("wr_instr", {32'd0, bus.wr_instr_o}, exp_instr_q.pop_front());
                check("wr_addr", bus.wr_addr_o, exp_addr_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [15:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            bus.byte_valid_i = 1'b0;
            @(negedge clk);
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        while (!bus.byte_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept", {63'd0, bus.byte_ready_o}, 64'd1);
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], gap);
    endtask

    task automatic expect_write(input logic [31:0] w, input logic [63:0] a);
        exp_instr_q.push_back({32'd0, w});
        exp_addr_q.push_back(a);
    endtask

    // Called on the strobe cycle of the last data word.
    task automatic close_load(input string tag, input logic [31:0] chk, input logic exp_err);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_word(chk, 1'b0);
        check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
`else
        @(negedge clk);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
`endif
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_no_strobe"}, {63'd0, bus.wr_instr_en_o}, 64'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] chk;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = '0;
        repeat (2) @(negedge clk);
        check("rst_state", 64'(state), 64'(S_IDLE));
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_ready", {63'd0, bus.byte_ready_o}, 64'd0);
        check("rst_wr_en", {63'd0, bus.wr_instr_en_o}, 64'd0);
        check("rst_wr_instr", {32'd0, bus.wr_instr_o}, 64'd0);
        check("rst_wr_addr", bus.wr_addr_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-length load completes immediately with no writes.
        write_count = 0;
        check("zero_done_before", {63'd0, done}, 64'd0);
        do_start(16'd0);
        check("zero_done", {63'd0, done}, 64'd1);
        check("zero_busy", {63'd0, busy}, 64'd0);
        repeat (4) @(negedge clk);
        check("zero_writes", 64'(write_count), 64'd0);

        // Two-word load, continuous and with valid gaps.
        for (int g = 0; g < 2; g++) begin
            write_count = 0;
            expect_write(32'h0000_0513, 64'd0);
            expect_write(32'h0010_0093, 64'd4);
            do_start(16'd2);
            check("two_done_clear", {63'd0, done}, 64'd0);
            send_word(32'h0000_0513, g[0]);
            check("two_strobe0", {63'd0, bus.wr_instr_en_o}, 64'd1);
            send_word(32'h0010_0093, g[0]);
            check("two_strobe1", {63'd0, bus.wr_instr_en_o}, 64'd1);
            close_load("two", 32'h0010_0580, 1'b0);
            check("two_writes", 64'(write_count), 64'd2);
            check("two_hold_instr", {32'd0, bus.wr_instr_o}, 64'h0010_0093);
            check("two_hold_addr", bus.wr_addr_o, 64'd4);
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        write_count = 0;
        expect_write(32'h0000_0513, 64'd0);
        expect_write(32'h0010_0093, 64'd4);
        do_start(16'd2);
        send_word(32'h0000_0513, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        close_load("chk_bad", 32'h0000_0000, 1'b1);
        check("chk_bad_writes", 64'(write_count), 64'd2);
`endif

        // Reset in the middle of a word discards it; the next load starts at address 0.
        write_count = 0;
        do_start(16'd2);
        send_byte(8'h13, 1'b0);
        send_byte(8'h05, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_state", 64'(state), 64'(S_IDLE));
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_ready", {63'd0, bus.byte_ready_o}, 64'd0);
        check("mid_rst_wr_addr", bus.wr_addr_o, 64'd0);
        check("mid_rst_wr_instr", {32'd0, bus.wr_instr_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_writes", 64'(write_count), 64'd0);
        expect_write(32'hdead_beef, 64'd0);
        do_start(16'd1);
        send_word(32'hdead_beef, 1'b0);
        check("restart_strobe", {63'd0, bus.wr_instr_en_o}, 64'd1);
        close_load("restart", 32'hdead_beef, 1'b0);

        // Oversized count clamps to 100 words; a start pulse mid-load is ignored.
        write_count = 0;
        chk = '0;
        do_start(16'd200);
        for (int i = 0; i < 100; i++) begin
            expect_write(32'h1000_0000 + 32'(i), 64'(4 * i));
            chk = chk ^ (32'h1000_0000 + 32'(i));
            send_word(32'h1000_0000 + 32'(i), 1'b0);
            check("long_strobe", {63'd0, bus.wr_instr_en_o}, 64'd1);
            if (i == 50) begin
                start     = 1'b1;
                num_words = 16'd3;
                repeat (2) @(negedge clk);
                start     = 1'b0;
                check("long_start_ignored_busy", {63'd0, busy}, 64'd1);
                check("long_start_ignored_state", 64'(state), 64'(S_ASSEMBLE));
            end
        end
        close_load("long", chk, 1'b0);
        check("long_writes", 64'(write_count), 64'd100);
        check("long_last_addr", bus.wr_addr_o, 64'd396);
        check("long_last_instr", {32'd0, bus.wr_instr_o}, 64'h1000_0063);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_instr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
